// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: registered RV32I(+M) control decoder with a valid/ready
// decode/execute pipeline register, a hold counter that models MUL/DIV
// latency, and a synchronous flush.
module pipe_ctrl_unit #(
    parameter logic EN_M    = 1'b1,
    parameter int   MUL_LAT = 2,
    parameter int   DIV_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [6:0] opcode,
    input  logic [6:0] funct7,
    input  logic [2:0] funct3,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       rf_en,
    output logic       dm_wr_en,
    output logic       dm_rd_en,
    output logic       csr_wr_en,
    output logic       opr_a_sel,
    output logic       opr_b_sel,
    output logic [1:0] wb_sel,
    output logic       m_op,
    output logic       m_div,
    output logic       illegal,
    output logic       busy
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_L = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_L = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] ONE_L = CNT_W'(1);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MWAIT = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load_bundle;
    logic             accept;

    // Combinational decode results
    logic       dec_rf, dec_dwr, dec_drd, dec_csr, dec_a, dec_b;
    logic [1:0] dec_wb;
    logic       dec_m, dec_div, dec_ill;
    logic       is_m_enc;
    logic [CNT_W-1:0] dec_lat;
    logic       dec_long;

    // Registered control bundle
    logic       rf_reg, dwr_reg, drd_reg, csr_reg, a_reg, b_reg;
    logic [1:0] wb_reg;
    logic       m_reg, div_reg, ill_reg;

    // Only funct3[2] selects the M-extension class; the low bits do not
    // affect any control here.
    logic unused_funct3;
    assign unused_funct3 = ^funct3[1:0];

    assign is_m_enc = (opcode == OPC_OP) && (funct7 == F7_MULDIV);

    // Decode opcode/funct fields into the control bundle
    always_comb begin
        dec_rf  = 1'b0;
        dec_dwr = 1'b0;
        dec_drd = 1'b0;
        dec_csr = 1'b0;
        dec_a   = 1'b0;
        dec_b   = 1'b0;
        dec_wb  = 2'b00;
        dec_m   = 1'b0;
        dec_div = 1'b0;
        dec_ill = 1'b0;
        case (opcode)
            OPC_OP: begin
                if (is_m_enc && !EN_M) begin
                    dec_ill = 1'b1;
                end else begin
                    dec_rf  = 1'b1;
                    dec_m   = is_m_enc;
                    dec_div = is_m_enc & funct3[2];
                end
            end
            OPC_OPIMM: begin
                dec_rf = 1'b1;
                dec_b  = 1'b1;
            end
            OPC_LOAD: begin
                dec_rf  = 1'b1;
                dec_drd = 1'b1;
                dec_b   = 1'b1;
                dec_wb  = 2'b01;
            end
            OPC_STORE: begin
                dec_dwr = 1'b1;
                dec_b   = 1'b1;
            end
            OPC_BRANCH: begin
                dec_a = 1'b1;
                dec_b = 1'b1;
            end
            OPC_JAL: begin
                dec_rf = 1'b1;
                dec_a  = 1'b1;
                dec_b  = 1'b1;
                dec_wb = 2'b10;
            end
            OPC_JALR: begin
                dec_rf = 1'b1;
                dec_b  = 1'b1;
                dec_wb = 2'b10;
            end
            OPC_LUI: begin
                dec_rf = 1'b1;
                dec_b  = 1'b1;
            end
            OPC_AUIPC: begin
                dec_rf = 1'b1;
                dec_a  = 1'b1;
                dec_b  = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_rf  = 1'b1;
                dec_a   = 1'b1;
                dec_wb  = 2'b11;
                dec_csr = 1'b1;
            end
            default: begin
                dec_ill = 1'b1;
            end
        endcase
    end

    assign dec_lat  = dec_div ? DIV_L : MUL_L;
    assign dec_long = dec_m && (dec_lat > ONE_L);

    // Ready is masked during reset so that every output reads 0 while rst_n is low
    assign in_ready = rst_n && !flush &&
                      ((state_reg == IDLE) || ((state_reg == ISSUE) && out_ready));
    assign accept   = in_valid && in_ready;

    // Next-state logic: accept into MWAIT or ISSUE, count down, drain on out_ready
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        load_bundle = 1'b0;
        case (state_reg)
            IDLE, ISSUE: begin
                if (accept) begin
                    load_bundle = 1'b1;
                    if (dec_long) begin
                        state_next = MWAIT;
                        cnt_next   = dec_lat - ONE_L;
                    end else begin
                        state_next = ISSUE;
                        cnt_next   = '0;
                    end
                end else if ((state_reg == ISSUE) && out_ready) begin
                    state_next = IDLE;
                end
            end
            MWAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ISSUE;
                end else begin
                    cnt_next = cnt_reg - ONE_L;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and hold-counter register; flush returns to IDLE below reset priority
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else if (flush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Decode/execute pipeline register: loads only on accept, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rf_reg  <= 1'b0;
            dwr_reg <= 1'b0;
            drd_reg <= 1'b0;
            csr_reg <= 1'b0;
            a_reg   <= 1'b0;
            b_reg   <= 1'b0;
            wb_reg  <= 2'b00;
            m_reg   <= 1'b0;
            div_reg <= 1'b0;
            ill_reg <= 1'b0;
        end else if (load_bundle) begin
            rf_reg  <= dec_rf;
            dwr_reg <= dec_dwr;
            drd_reg <= dec_drd;
            csr_reg <= dec_csr;
            a_reg   <= dec_a;
            b_reg   <= dec_b;
            wb_reg  <= dec_wb;
            m_reg   <= dec_m;
            div_reg <= dec_div;
            ill_reg <= dec_ill;
        end
    end

    assign out_valid = (state_reg == ISSUE);
    assign busy      = (state_reg == MWAIT);
    assign rf_en     = rf_reg;
    assign dm_wr_en  = dwr_reg;
    assign dm_rd_en  = drd_reg;
    assign csr_wr_en = csr_reg;
    assign opr_a_sel = a_reg;
    assign opr_b_sel = b_reg;
    assign wb_sel    = wb_reg;
    assign m_op      = m_reg;
    assign m_div     = div_reg;
    assign illegal   = ill_reg && out_valid;

endmodule
